// File: rtl/jpeg_bit_reader_if.sv
// Handshake bundle between the byte source, the request/response consumer and jpeg_bit_reader.
// The reader itself connects through the slave modport.
interface jpeg_bit_reader_if #(
    parameter int MAX_LEN = 16
);
    logic [7:0]         byte_in;
    logic               byte_valid;
    logic               byte_ready;
    logic [4:0]         req_len;
    logic               req_ext;
    logic               req_valid;
    logic               req_ready;
    logic [MAX_LEN-1:0] out_data;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output byte_in, byte_valid, req_len, req_ext, req_valid, out_ready,
        input  byte_ready, req_ready, out_data, out_valid
    );

    modport slave (
        input  byte_in, byte_valid, req_len, req_ext, req_valid, out_ready,
        output byte_ready, req_ready, out_data, out_valid
    );
endinterface

// File: rtl/jpeg_bit_reader.sv
// JPEG entropy bitstream reader: strips 0xFF00 stuffing, detects markers and hands out
// fixed-length bit fields (raw or EXTEND sign-decoded) from a left-aligned bit buffer.
module jpeg_bit_reader #(
    parameter int MAX_LEN = 16,
    parameter int BUF_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   align,
    jpeg_bit_reader_if.slave       bus,
    output logic [MAX_LEN-1:0]     peek,
    output logic [$clog2(BUF_W):0] bit_cnt,
    output logic                   marker_det,
    output logic [7:0]             marker_code,
    output logic                   underflow
);

    localparam int CNT_W = $clog2(BUF_W) + 1;

    typedef enum logic [1:0] {
        S_NORM,
        S_FF,
        S_MARK
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [BUF_W-1:0]   buf_q;
    logic [BUF_W-1:0]   buf_cons;
    logic [BUF_W-1:0]   buf_next;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_cons;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   len_w;
    logic [CNT_W-1:0]   top_shift;

    logic               in_mark;
    logic               byte_acc;
    logic               req_acc;
    logic               short_req;
    logic               append_en;
    logic [7:0]         append_byte;
    logic               marker_hit;

    logic [MAX_LEN-1:0] field_raw;
    logic [MAX_LEN-1:0] field_ext;
    logic               field_sign;
    logic [MAX_LEN-1:0] out_data_q;
    logic               out_valid_q;

    // ---------------- input FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state <= S_NORM;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- input FSM: next state ----------------
    always_comb begin
        state_next = state;
        if (byte_acc) begin
            case (state)
                S_NORM:  if (bus.byte_in == 8'hFF) state_next = S_FF;
                S_FF: begin
                    if (bus.byte_in == 8'h00) begin
                        state_next = S_NORM;
                    end else if (bus.byte_in != 8'hFF) begin
                        state_next = S_MARK;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    // ---------------- input FSM: outputs ----------------
    // A stuffed FF00 pair appends a single 0xFF; repeated FFs are fill bytes and append nothing.
    always_comb begin
        in_mark        = (state == S_MARK);
        bus.byte_ready = (cnt_q <= CNT_W'(BUF_W - 8)) && !in_mark;
        append_en      = 1'b0;
        append_byte    = bus.byte_in;
        marker_hit     = 1'b0;
        if (byte_acc) begin
            case (state)
                S_NORM: append_en = (bus.byte_in != 8'hFF);
                S_FF: begin
                    append_en   = (bus.byte_in == 8'h00);
                    append_byte = 8'hFF;
                    marker_hit  = (bus.byte_in != 8'h00) && (bus.byte_in != 8'hFF);
                end
                default: append_en = 1'b0;
            endcase
        end
    end

    assign byte_acc = bus.byte_valid && bus.byte_ready;

    // ---------------- request handshake ----------------
    assign len_w         = CNT_W'(bus.req_len);
    assign short_req     = (cnt_q < len_w);
    assign bus.req_ready = (!out_valid_q || bus.out_ready) && (!short_req || in_mark) && !align;
    assign req_acc       = bus.req_valid && bus.req_ready;

    // Bits past cnt_q are always zero, so an underflowing request is zero-filled for free.
    assign top_shift  = CNT_W'(MAX_LEN) - len_w;
    assign field_raw  = buf_q[BUF_W-1 -: MAX_LEN] >> top_shift;
    assign field_sign = |(field_raw & (MAX_LEN'(1) << (len_w - CNT_W'(1))));

    always_comb begin
        field_ext = '0;
        if (len_w != '0) begin
            if (field_sign) begin
                field_ext = field_raw;
            end else begin
                field_ext = field_raw - (MAX_LEN'(1) << len_w) + MAX_LEN'(1);
            end
        end
    end

    // ---------------- buffer update: consume/align first, then append ----------------
    always_comb begin
        buf_cons = buf_q;
        cnt_cons = cnt_q;
        if (align) begin
            buf_cons = buf_q << cnt_q[2:0];
            cnt_cons = cnt_q - CNT_W'(cnt_q[2:0]);
        end else if (req_acc) begin
            buf_cons = buf_q << len_w;
            cnt_cons = short_req ? '0 : (cnt_q - len_w);
        end
        buf_next = buf_cons;
        cnt_next = cnt_cons;
        if (append_en) begin
            buf_next = buf_cons | ({append_byte, {(BUF_W-8){1'b0}}} >> cnt_cons);
            cnt_next = cnt_cons + CNT_W'(8);
        end
    end

    // ---------------- registered datapath and status ----------------
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            buf_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            marker_det  <= 1'b0;
            marker_code <= 8'h00;
            underflow   <= 1'b0;
        end else begin
            buf_q <= buf_next;
            cnt_q <= cnt_next;
            if (req_acc) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.req_ext ? field_ext : field_raw;
                if (short_req) begin
                    underflow <= 1'b1;
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (marker_hit) begin
                marker_det  <= 1'b1;
                marker_code <= bus.byte_in;
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign peek          = buf_q[BUF_W-1 -: MAX_LEN];
    assign bit_cnt       = cnt_q;

endmodule

// File: tb/tb_jpeg_bit_reader.sv
// Self-checking bench for jpeg_bit_reader: directed scenarios plus a randomized stream
// checked against a bit-queue model of destuffing, extraction and EXTEND.
module tb_jpeg_bit_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        align;
    logic [15:0] peek;
    logic [5:0]  bit_cnt;
    logic        marker_det;
    logic [7:0]  marker_code;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    jpeg_bit_reader_if #(.MAX_LEN(16)) bif ();

    jpeg_bit_reader #(.MAX_LEN(16), .BUF_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .align       (align),
        .bus         (bif),
        .peek        (peek),
        .bit_cnt     (bit_cnt),
        .marker_det  (marker_det),
        .marker_code (marker_code),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    // Requests longer than MAX_LEN are outside the legal operating range.
    always @(posedge clk) begin
        if (bif.req_valid && !rst) begin
            assert (bif.req_len <= 5'd16) else $error("[TB] illegal req_len %0d", bif.req_len);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // ---------------- reference model: a plain queue of bits ----------------
    bit       mq[$];
    bit       m_ff;
    bit       m_mark;
    bit       m_uf;
    logic [7:0] m_code;

    function automatic void model_clear();
        mq.delete();
        m_ff   = 0;
        m_mark = 0;
        m_uf   = 0;
        m_code = 8'h00;
    endfunction

    function automatic void model_append(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
    endfunction

    function automatic void model_push(input logic [7:0] b);
        if (m_mark) return;
        if (!m_ff) begin
            if (b == 8'hFF) m_ff = 1;
            else            model_append(b);
        end else if (b == 8'h00) begin
            model_append(8'hFF);
            m_ff = 0;
        end else if (b != 8'hFF) begin
            m_mark = 1;
            m_code = b;
            m_ff   = 0;
        end
    endfunction

    function automatic logic [15:0] model_pop(input int len, input bit ext);
        int v = 0;
        for (int i = 0; i < len; i++) begin
            v = v * 2;
            if (mq.size() > 0) v += int'(mq.pop_front());
            else               m_uf = 1;
        end
        if (ext && len > 0 && v < (1 << (len - 1))) v = v - (1 << len) + 1;
        return 16'(v);
    endfunction

    function automatic logic [15:0] model_peek();
        logic [15:0] p = 16'h0000;
        for (int i = 0; i < 16; i++) p = {p[14:0], (i < mq.size()) ? mq[i] : 1'b0};
        return p;
    endfunction

    function automatic void model_align();
        int drop = mq.size() % 8;
        for (int i = 0; i < drop; i++) void'(mq.pop_front());
    endfunction

    // ---------------- drivers ----------------
    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bif.byte_in    = b;
        bif.byte_valid = 1'b1;
        #1;
        while (!bif.byte_ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!bif.byte_ready) begin
            failures++;
            $display("[TB] FAIL byte_accept timeout byte=%02h got ready=0 need ready=1", b);
        end else begin
            model_push(b);
        end
        @(posedge clk);
        #1;
        bif.byte_valid = 1'b0;
    endtask

    task automatic do_req(input int len, input bit ext,
                          output logic [15:0] obs, output logic [15:0] exp_v, output logic vld);
        int n = 0;
        @(negedge clk);
        bif.req_len   = 5'(len);
        bif.req_ext   = ext;
        bif.req_valid = 1'b1;
        #1;
        while (!bif.req_ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!bif.req_ready) begin
            failures++;
            $display("[TB] FAIL req_accept timeout len=%0d got ready=0 need ready=1", len);
            bif.req_valid = 1'b0;
            obs   = 16'hxxxx;
            exp_v = 16'h0000;
            vld   = 1'b0;
            return;
        end
        exp_v = model_pop(len, ext);
        @(posedge clk);
        #1;
        bif.req_valid = 1'b0;
        obs = bif.out_data;
        vld = bif.out_valid;
    endtask

    task automatic pulse(input bit use_rst);
        @(negedge clk);
        if (use_rst) rst = 1'b1;
        else         clr = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clr = 1'b0;
        model_clear();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bit_cnt !== 6'd0)     begin failures++; $display("[TB] FAIL reset_bit_cnt got=%0d exp=0", bit_cnt); end
        checks++; if (peek !== 16'h0000)    begin failures++; $display("[TB] FAIL reset_peek got=%h exp=0000", peek); end
        checks++; if (bif.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", bif.out_valid); end
        checks++; if (bif.out_data !== 16'h0) begin failures++; $display("[TB] FAIL reset_out_data got=%h exp=0000", bif.out_data); end
        checks++; if (marker_det !== 1'b0 || marker_code !== 8'h00) begin failures++; $display("[TB] FAIL reset_marker got=%b/%h exp=0/00", marker_det, marker_code); end
        checks++; if (underflow !== 1'b0)   begin failures++; $display("[TB] FAIL reset_underflow got=%b exp=0", underflow); end
        checks++; if (bif.byte_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_byte_ready got=%b exp=1", bif.byte_ready); end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_basic();
        logic [15:0] obs, e, exp_tab[4];
        logic vld;
        exp_tab = '{16'hA, 16'h5, 16'h3, 16'hC};
        push_byte(8'hA5);
        push_byte(8'h3C);
        for (int i = 0; i < 4; i++) begin
            do_req(4, 0, obs, e, vld);
            checks++;
            if (obs !== exp_tab[i] || vld !== 1'b1) begin
                failures++;
                $display("[TB] FAIL basic_nibble%0d got=%h/v%b exp=%h/v1", i, obs, vld, exp_tab[i]);
            end
        end
        checks++; if (bit_cnt !== 6'd0) begin failures++; $display("[TB] FAIL basic_bit_cnt got=%0d exp=0", bit_cnt); end
    endtask

    task automatic test_stuffing();
        logic [15:0] obs, e;
        logic vld;
        push_byte(8'hFF);
        push_byte(8'h00);
        push_byte(8'h80);
        checks++; if (peek !== 16'hFF80) begin failures++; $display("[TB] FAIL stuff_peek got=%h exp=FF80", peek); end
        checks++; if (bit_cnt !== 6'd16) begin failures++; $display("[TB] FAIL stuff_bit_cnt got=%0d exp=16", bit_cnt); end
        do_req(8, 0, obs, e, vld);
        checks++; if (obs !== 16'h00FF) begin failures++; $display("[TB] FAIL stuff_byte0 got=%h exp=00FF", obs); end
        do_req(8, 0, obs, e, vld);
        checks++; if (obs !== 16'h0080) begin failures++; $display("[TB] FAIL stuff_byte1 got=%h exp=0080", obs); end
    endtask

    task automatic test_extend();
        logic [15:0] obs, e;
        logic vld;
        push_byte(8'h5A);
        do_req(3, 1, obs, e, vld);
        checks++; if (obs !== 16'hFFFB) begin failures++; $display("[TB] FAIL ext_len3 got=%h exp=FFFB", obs); end
        do_req(5, 1, obs, e, vld);
        checks++; if (obs !== 16'h001A) begin failures++; $display("[TB] FAIL ext_len5 got=%h exp=001A", obs); end
        do_req(0, 1, obs, e, vld);
        checks++; if (obs !== 16'h0000 || vld !== 1'b1) begin failures++; $display("[TB] FAIL ext_len0 got=%h/v%b exp=0000/v1", obs, vld); end
        push_byte(8'h00);
        push_byte(8'h01);
        do_req(16, 1, obs, e, vld);
        checks++; if (obs !== 16'h0002) begin failures++; $display("[TB] FAIL ext_len16_neg got=%h exp=0002", obs); end
        push_byte(8'h80);
        push_byte(8'h00);
        do_req(16, 1, obs, e, vld);
        checks++; if (obs !== 16'h8000) begin failures++; $display("[TB] FAIL ext_len16_pos got=%h exp=8000", obs); end
    endtask

    task automatic test_marker();
        logic [15:0] obs, e;
        logic vld;
        push_byte(8'hFF);
        push_byte(8'hD9);
        checks++; if (marker_det !== 1'b1)   begin failures++; $display("[TB] FAIL marker_det got=%b exp=1", marker_det); end
        checks++; if (marker_code !== 8'hD9) begin failures++; $display("[TB] FAIL marker_code got=%h exp=D9", marker_code); end
        checks++; if (bif.byte_ready !== 1'b0) begin failures++; $display("[TB] FAIL marker_byte_ready got=%b exp=0", bif.byte_ready); end
        do_req(8, 0, obs, e, vld);
        checks++; if (obs !== 16'h0000 || vld !== 1'b1) begin failures++; $display("[TB] FAIL marker_zero_fill got=%h/v%b exp=0000/v1", obs, vld); end
        checks++; if (underflow !== 1'b1) begin failures++; $display("[TB] FAIL marker_underflow got=%b exp=1", underflow); end
        pulse(0);
        checks++; if (marker_det !== 1'b0 || underflow !== 1'b0 || bif.out_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL marker_clr got=%b%b%b exp=000", marker_det, underflow, bif.out_valid);
        end
        checks++; if (bif.byte_ready !== 1'b1) begin failures++; $display("[TB] FAIL marker_clr_ready got=%b exp=1", bif.byte_ready); end
    endtask

    task automatic test_back_to_back();
        fork
            begin
                push_byte(8'h12);
                push_byte(8'h34);
                push_byte(8'h56);
                push_byte(8'h78);
            end
            begin
                logic [15:0] obs, e;
                logic vld;
                for (int k = 0; k < 8; k++) begin
                    do_req(4, 0, obs, e, vld);
                    checks++;
                    if (obs !== 16'(k + 1) || vld !== 1'b1) begin
                        failures++;
                        $display("[TB] FAIL stream_nibble%0d got=%h/v%b exp=%h/v1", k, obs, vld, 16'(k + 1));
                    end
                    if (k == 3) begin
                        bif.out_ready = 1'b0;
                        for (int h = 0; h < 5; h++) begin
                            @(negedge clk);
                            bif.req_len   = 5'd4;
                            bif.req_valid = 1'b1;
                            #1;
                            checks++;
                            if (bif.out_data !== 16'h0004 || bif.out_valid !== 1'b1 || bif.req_ready !== 1'b0) begin
                                failures++;
                                $display("[TB] FAIL stream_hold%0d got=%h/v%b/r%b exp=0004/v1/r0", h, bif.out_data, bif.out_valid, bif.req_ready);
                            end
                        end
                        bif.req_valid = 1'b0;
                        bif.out_ready = 1'b1;
                    end
                end
            end
        join
        checks++; if (bit_cnt !== 6'd0) begin failures++; $display("[TB] FAIL stream_bit_cnt got=%0d exp=0", bit_cnt); end
    endtask

    task automatic test_random();
        fork
            begin
                logic [7:0] b;
                for (int i = 0; i < 40; i++) begin
                    b = 8'($urandom_range(0, 255));
                    if (i % 7 == 3) b = 8'hFF;
                    push_byte(b);
                    if (b == 8'hFF) push_byte(8'h00);
                end
            end
            begin
                logic [15:0] obs, e;
                logic vld;
                int consumed = 0;
                int len;
                bit ext;
                while (consumed < 320) begin
                    len = $urandom_range(0, 16);
                    if (len > 320 - consumed) len = 320 - consumed;
                    ext = 1'($urandom_range(0, 1));
                    do_req(len, ext, obs, e, vld);
                    checks++;
                    if (obs !== e || vld !== 1'b1) begin
                        failures++;
                        $display("[TB] FAIL rand_field len=%0d ext=%0d got=%h/v%b exp=%h/v1", len, ext, obs, vld, e);
                    end
                    consumed += len;
                    if ($urandom_range(0, 3) == 0) begin
                        bif.out_ready = 1'b0;
                        repeat (2) begin
                            @(negedge clk);
                            #1;
                            checks++;
                            if (bif.out_data !== e || bif.out_valid !== 1'b1) begin
                                failures++;
                                $display("[TB] FAIL rand_hold got=%h/v%b exp=%h/v1", bif.out_data, bif.out_valid, e);
                            end
                        end
                        bif.out_ready = 1'b1;
                    end
                end
            end
        join
        checks++; if (bit_cnt !== 6'(mq.size())) begin failures++; $display("[TB] FAIL rand_bit_cnt got=%0d exp=%0d", bit_cnt, mq.size()); end
        checks++; if (underflow !== m_uf) begin failures++; $display("[TB] FAIL rand_underflow got=%b exp=%b", underflow, m_uf); end
    endtask

    task automatic test_align_clear();
        logic [15:0] obs, e;
        logic vld;
        push_byte(8'hC3);
        push_byte(8'h5E);
        do_req(3, 0, obs, e, vld);
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL align_pre got=%h exp=%h", obs, e); end
        @(negedge clk);
        align         = 1'b1;
        bif.req_len   = 5'd0;
        bif.req_valid = 1'b1;
        #1;
        checks++; if (bif.req_ready !== 1'b0) begin failures++; $display("[TB] FAIL align_req_ready got=%b exp=0", bif.req_ready); end
        @(posedge clk);
        #1;
        align         = 1'b0;
        bif.req_valid = 1'b0;
        model_align();
        checks++; if (bit_cnt !== 6'd8) begin failures++; $display("[TB] FAIL align_bit_cnt got=%0d exp=8", bit_cnt); end
        checks++; if (peek !== model_peek()) begin failures++; $display("[TB] FAIL align_peek got=%h exp=%h", peek, model_peek()); end
        pulse(0);
        checks++; if (bit_cnt !== 6'd0 || peek !== 16'h0000) begin failures++; $display("[TB] FAIL clr_buffer got=%0d/%h exp=0/0000", bit_cnt, peek); end
        push_byte(8'h11);
        push_byte(8'h22);
        do_req(4, 0, obs, e, vld);
        pulse(1);
        checks++;
        if (bit_cnt !== 6'd0 || peek !== 16'h0000 || bif.out_valid !== 1'b0 || bif.out_data !== 16'h0000 ||
            marker_det !== 1'b0 || marker_code !== 8'h00 || underflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_midstream got cnt=%0d peek=%h ov=%b od=%h md=%b mc=%h uf=%b exp all zero",
                     bit_cnt, peek, bif.out_valid, bif.out_data, marker_det, marker_code, underflow);
        end
    endtask

    initial begin
        rst            = 1'b1;
        clr            = 1'b0;
        align          = 1'b0;
        bif.byte_in    = 8'h00;
        bif.byte_valid = 1'b0;
        bif.req_len    = 5'd0;
        bif.req_ext    = 1'b0;
        bif.req_valid  = 1'b0;
        bif.out_ready  = 1'b1;
        model_clear();

        test_reset();
        test_basic();
        test_stuffing();
        test_extend();
        test_marker();
        test_back_to_back();
        test_random();
        test_align_clear();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
